// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width and
// multiplier FSM encodings.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/cla_adder32.sv
// 32-bit carry-look-ahead adder: 4-bit groups with
// group generate/propagate feeding a block carry chain.
module cla_adder32 (
  output logic        cout,
  output logic [31:0] sum,
  input  logic [31:0] a,
  input  logic [31:0] b
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int i = 0; i < 8; i++) begin
      gp[i] = &p[4*i +: 4];
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | ((&p[4*i+2 +: 2]) & g[4*i+1])
            | ((&p[4*i+1 +: 3]) & g[4*i]);
      gc[i+1] = gg[i] | (gp[i] & gc[i]);
    end
    for (int i = 0; i < 8; i++) begin
      c[4*i] = gc[i];
      for (int j = 0; j < 3; j++) begin
        c[4*i+j+1] = g[4*i+j] | (p[4*i+j] & c[4*i+j]);
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[8];

endmodule

// File: rtl/mul32_seq.sv
// Sequential 32x32->64 unsigned shift-add multiplier
// built around the shared cla_adder32.
module mul32_seq
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*XLEN-1:0] product
);

  localparam logic [4:0] LAST = 5'(MUL_ITERS - 1);

  mul_state_t      state;
  mul_state_t      state_n;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [4:0]      cnt;
  logic [XLEN-1:0] add_b;
  logic [XLEN-1:0] sum;
  logic            cout;

  // Only the operand mux sits in front of the adder.
  assign add_b = lo[0] ? mcand : '0;

  cla_adder32 u_add (
    .cout (cout),
    .sum  (sum),
    .a    (hi),
    .b    (add_b)
  );

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == MUL_IDLE): begin
        in_ready = rst_n;
        if (in_valid) state_n = MUL_RUN;
      end
      (state == MUL_RUN): begin
        if (cnt == LAST) state_n = MUL_DONE;
      end
      (state == MUL_DONE): begin
        out_valid = 1'b1;
        if (out_ready) state_n = MUL_IDLE;
      end
      default: state_n = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MUL_IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == MUL_IDLE && in_valid) begin
        mcand <= a;
        lo    <= b;
        hi    <= '0;
        cnt   <= '0;
      end else if (state == MUL_RUN) begin
        {hi, lo} <= {cout, sum, lo[XLEN-1:1]};
        cnt      <= cnt + 5'd1;
      end
    end
  end

  assign product = {hi, lo};

endmodule
